// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W data bits LSB first plus one parity bit, reporting word and parity error.
// Optional 8-bit saturating parity error counter on port err_cnt when PARITY_ERR_CNT_EN is defined.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              frame_start,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int   CNT_W   = $clog2(DATA_W) + 1;
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;
    logic                xor_reg;
    logic                frame_err_next;

    // Each data bit lands at the position addressed by the bit counter.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ins
            assign shift_next[gi] = (bit_cnt_reg == CNT_W'(gi)) ? in_bit : shift_reg[gi];
        end
    endgenerate

    assign frame_err_next = xor_reg ^ in_bit ^ ODD_BIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            xor_reg     <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            parity_err  <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
            err_cnt     <= 8'd0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (frame_start) begin
                    // A start bit always begins a fresh frame, aborting any frame in flight.
                    state_reg   <= DATA;
                    bit_cnt_reg <= CNT_W'(1);
                    shift_reg   <= {{(DATA_W-1){1'b0}}, in_bit};
                    xor_reg     <= in_bit;
                    busy        <= 1'b1;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            state_reg <= IDLE;
                        end
                        DATA: begin
                            shift_reg   <= shift_next;
                            xor_reg     <= xor_reg ^ in_bit;
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                                state_reg <= PARITY;
                            end
                        end
                        PARITY: begin
                            state_reg   <= IDLE;
                            busy        <= 1'b0;
                            bit_cnt_reg <= '0;
                            out_valid   <= 1'b1;
                            out_data    <= shift_reg;
                            parity_err  <= frame_err_next;
`ifdef PARITY_ERR_CNT_EN
                            if (frame_err_next && (err_cnt != 8'hFF)) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
`endif
                        end
                        default: begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (valid range 2..32).
REQ-002 SHALL have parameter ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_bit (and frame_start) are accepted this cycle.
REQ-006 SHALL have port in_bit  input  1  serial line bit; data is sent LSB first, followed by one parity bit.
REQ-007 SHALL have port frame_start  input  1  marks the accepted bit as data bit 0 of a new frame.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress (state DATA or PARITY).
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse reporting that a frame has completed.
REQ-010 SHALL have port out_data  output  DATA_W  the received data word.
REQ-011 SHALL have port parity_err  output  1  parity mismatch flag for the frame reported with out_valid.

Function
REQ-012 SHALL implement FSM states IDLE, DATA and PARITY.
REQ-013 In IDLE, when in_valid=1 and frame_start=1, the block SHALL store in_bit as bit 0, set bit count to 1 and go to DATA.
REQ-014 In IDLE, any accepted bit without frame_start SHALL be ignored; frame_start without in_valid SHALL be ignored in every state.
REQ-015 In DATA, each accepted bit SHALL be stored at position bit count and bit count SHALL increment; after bit DATA_W-1 the FSM SHALL go to PARITY.
REQ-016 A running XOR of the accepted data bits SHALL be kept and cleared at each frame start.
REQ-017 In PARITY, the accepted bit SHALL be the parity bit; the FSM SHALL then return to IDLE and compute err = running XOR ^ parity bit ^ ODD.
REQ-018 In the cycle after the parity bit is accepted, out_valid SHALL be 1 for exactly one cycle, with out_data and parity_err set to the frame values (latency is 1 cycle).
REQ-019 out_data and parity_err SHALL hold their values until the next out_valid pulse.
REQ-020 When in_valid=0, the FSM, bit count, shift data and XOR SHALL hold (a stall), with no timeout.
REQ-021 An accepted frame_start in DATA or PARITY SHALL abort the current frame with no out_valid and restart it with this bit as bit 0.
REQ-022 A frame_start accepted in the same cycle as the final parity bit would otherwise be consumed SHALL be treated as an abort/restart per REQ-021, so the parity bit is not consumed.
REQ-023 busy SHALL be 1 in DATA and PARITY and 0 in IDLE.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL enter IDLE and clear bit count, the XOR and shift data, and set busy=0, out_valid=0, out_data=0 and parity_err=0.
REQ-025 Reset mid-frame SHALL discard the partial frame without any out_valid; rst SHALL take priority over all inputs in the same cycle.

Configuration
REQ-026 With macro PARITY_ERR_CNT_EN defined, the block SHALL add output err_cnt (8 bits), which increments on each out_valid with parity_err=1, saturates at 255 and is cleared only by rst.
REQ-027 Without PARITY_ERR_CNT_EN, port err_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 With DATA_W=8 and ODD=0, send bits 1,0,1,0,0,1,0,1 with parity 0 on consecutive cycles -> one cycle later out_valid=1, out_data=0xA5, parity_err=0.
REQ-029 Same frame with parity 1 -> out_data=0xA5, parity_err=1; with PARITY_ERR_CNT_EN, err_cnt goes from 0 to 1.
REQ-030 Same frame with ODD=1 and parity 1 -> parity_err=0; with in_valid low for 3 cycles after data bit 4 -> same result, out_valid delayed 3 cycles, busy stays 1 during the gap.
REQ-031 Send 5 bits of a frame, then frame_start with 0xFF and parity 0 -> only one out_valid, out_data=0xFF, parity_err=0.
REQ-032 Assert rst after data bit 3 -> busy=0 the next cycle, no out_valid, outputs 0; a following 0x3C frame with parity 0 reports 0x3C with parity_err=0.
REQ-033 With PARITY_ERR_CNT_EN, send 260 frames with bad parity -> err_cnt reads 255 and stays at 255.
